// File: rtl/lmfe_window_ctrl_if.sv
// Handshake and bus signals between the LMFE window controller, the frame RAM
// and the external rank sorter.
interface lmfe_window_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          START;
    logic          PAD;
    logic [AW-1:0] A;
    logic          RE;
    logic [DW-1:0] Q;
    logic          SCLR;
    logic          SE;
    logic [DW-1:0] INS;
    logic [DW-1:0] DEL;
    logic          DEL_EN;
    logic [DW-1:0] MED;
    logic [DW-1:0] DOUT;
    logic          OV;
    logic          BZ;
    logic          DONE;

    modport master (
        input  START, PAD, Q, MED,
        output A, RE, SCLR, SE, INS, DEL, DEL_EN, DOUT, OV, BZ, DONE
    );

    modport slave (
        output START, PAD, Q, MED,
        input  A, RE, SCLR, SE, INS, DEL, DEL_EN, DOUT, OV, BZ, DONE
    );
endinterface

// File: rtl/lmfe_window_ctrl.sv
// WIN x WIN sliding-median controller: walks the frame in raster order, feeds an
// insert/delete rank sorter and emits one median per pixel.
module lmfe_window_ctrl #(
    parameter int DW      = 8,
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int WIN     = 7,
    parameter int AW      = 14,
    parameter int MED_LAT = 1
) (
    input logic               clk,
    input logic               RST,
    lmfe_window_ctrl_if.master bus
);
    localparam int N  = WIN * WIN;
    localparam int H  = (WIN - 1) / 2;
    localparam int RW = $clog2(WIN);
    localparam int KW = $clog2(N + 2);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_SLIDE, S_WAIT, S_EMIT, S_FIN
    } state_t;

    state_t        state;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          pad_r;
    logic [KW-1:0] k;
    logic [RW-1:0] lc, lr, nlc, nlr, op_col, op_row;
    logic          op_q;
    logic [7:0]    wcnt;
    logic [DW-1:0] win [WIN][WIN];

    logic [AW-1:0] a_r;
    logic          re_r, sclr_r, se_r, del_en_r, ov_r, bz_r, done_r;
    logic [DW-1:0] ins_r, del_r, dout_r, ins_v;

    int            ix, iy;
    logic [AW:0]   iss;

    // {read-enable, address}; clamping happens before the multiply so the
    // address never leaves the frame.
    function automatic logic [AW:0] tap(input int x, input int y, input logic pad);
        int   xc, yc;
        logic inr;
        xc  = (x < 0) ? 0 : ((x > IMG_W - 1) ? IMG_W - 1 : x);
        yc  = (y < 0) ? 0 : ((y > IMG_H - 1) ? IMG_H - 1 : y);
        inr = (xc == x) && (yc == y);
        return {inr | pad, AW'(yc * IMG_W + xc)};
    endfunction

    // Coordinates of the next read to issue, one cycle ahead of its sorter op.
    always_comb begin
        nlc = (lr == RW'(WIN - 1)) ? lc + RW'(1) : lc;
        nlr = (lr == RW'(WIN - 1)) ? '0 : lr + RW'(1);
        ix  = int'(cx) - H;
        iy  = int'(cy) - H;
        case (state)
            S_LOAD:  begin ix = int'(cx) - H + int'(nlc); iy = int'(cy) - H + int'(nlr); end
            S_SLIDE: begin ix = int'(cx) + H;             iy = int'(cy) - H + int'(lr) + 1; end
            S_EMIT:  begin ix = int'(cx) + 1 + H;         iy = int'(cy) - H; end
            default: ;
        endcase
        iss = tap(ix, iy, pad_r);
    end

    // Q arrives in the op cycle itself, so INS is muxed straight from it.
    always_comb begin
        ins_v = ins_r;
        if (!se_r) ins_v = op_q ? bus.Q : '0;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= S_IDLE;
            cx       <= '0;
            cy       <= '0;
            pad_r    <= 1'b0;
            k        <= '0;
            lc       <= '0;
            lr       <= '0;
            op_col   <= '0;
            op_row   <= '0;
            op_q     <= 1'b0;
            wcnt     <= '0;
            a_r      <= '0;
            re_r     <= 1'b0;
            sclr_r   <= 1'b0;
            se_r     <= 1'b1;
            del_en_r <= 1'b0;
            ov_r     <= 1'b0;
            bz_r     <= 1'b0;
            done_r   <= 1'b0;
            ins_r    <= '0;
            del_r    <= '0;
            dout_r   <= '0;
            for (int c = 0; c < WIN; c++)
                for (int r = 0; r < WIN; r++)
                    win[c][r] <= '0;
        end else begin
            // Window file tracks exactly what the sorter holds.
            if (!se_r) begin
                ins_r <= ins_v;
                if (del_en_r) begin
                    for (int c = 0; c < WIN - 1; c++) win[c][op_row] <= win[c+1][op_row];
                    win[WIN-1][op_row] <= ins_v;
                end else begin
                    win[op_col][op_row] <= ins_v;
                end
            end

            case (state)
                S_IDLE: if (bus.START) begin
                    state  <= S_CLR;
                    bz_r   <= 1'b1;
                    cx     <= '0;
                    cy     <= '0;
                    pad_r  <= bus.PAD;
                    sclr_r <= 1'b1;
                end
                S_CLR: begin
                    sclr_r <= 1'b0;
                    state  <= S_LOAD;
                    k      <= '0;
                    lc     <= '0;
                    lr     <= '0;
                    re_r   <= iss[AW];
                    if (iss[AW]) a_r <= iss[AW-1:0];
                end
                S_LOAD: begin
                    if (k < KW'(N)) begin
                        se_r     <= 1'b0;
                        del_en_r <= 1'b0;
                        op_q     <= re_r;
                        op_col   <= lc;
                        op_row   <= lr;
                        k        <= k + KW'(1);
                        if (k < KW'(N - 1)) begin
                            lc   <= nlc;
                            lr   <= nlr;
                            re_r <= iss[AW];
                            if (iss[AW]) a_r <= iss[AW-1:0];
                        end else begin
                            re_r <= 1'b0;
                        end
                    end else begin
                        se_r  <= 1'b1;
                        state <= S_WAIT;
                        wcnt  <= '0;
                    end
                end
                S_SLIDE: begin
                    if (k < KW'(WIN)) begin
                        se_r     <= 1'b0;
                        del_en_r <= 1'b1;
                        del_r    <= win[0][lr];
                        op_q     <= re_r;
                        op_row   <= lr;
                        k        <= k + KW'(1);
                        if (k < KW'(WIN - 1)) begin
                            lr   <= lr + RW'(1);
                            re_r <= iss[AW];
                            if (iss[AW]) a_r <= iss[AW-1:0];
                        end else begin
                            re_r <= 1'b0;
                        end
                    end else begin
                        se_r     <= 1'b1;
                        del_en_r <= 1'b0;
                        state    <= S_WAIT;
                        wcnt     <= '0;
                    end
                end
                S_WAIT: begin
                    if (wcnt == 8'(MED_LAT - 1)) begin
                        state  <= S_EMIT;
                        ov_r   <= 1'b1;
                        dout_r <= bus.MED;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                S_EMIT: begin
                    ov_r <= 1'b0;
                    if (int'(cx) < IMG_W - 1) begin
                        cx    <= cx + XW'(1);
                        state <= S_SLIDE;
                        k     <= '0;
                        lr    <= '0;
                        re_r  <= iss[AW];
                        if (iss[AW]) a_r <= iss[AW-1:0];
                    end else begin
                        cx <= '0;
                        if (int'(cy) < IMG_H - 1) begin
                            cy     <= cy + YW'(1);
                            state  <= S_CLR;
                            sclr_r <= 1'b1;
                        end else begin
                            state  <= S_FIN;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done_r <= 1'b0;
                    bz_r   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.A      = a_r;
    assign bus.RE     = re_r;
    assign bus.SCLR   = sclr_r;
    assign bus.SE     = se_r;
    assign bus.INS    = ins_v;
    assign bus.DEL    = del_r;
    assign bus.DEL_EN = del_en_r;
    assign bus.DOUT   = dout_r;
    assign bus.OV     = ov_r;
    assign bus.BZ     = bz_r;
    assign bus.DONE   = done_r;
endmodule

// File: tb/tb_lmfe_window_ctrl.sv
// Bench for lmfe_window_ctrl: 3x3 window on a 4x4 frame, RAM and counting
// rank sorter modelled here, results checked against a table and a direct median.
module tb_lmfe_window_ctrl;
    localparam int DW = 8, W = 4, HT = 4, WN = 3, AW = 4, ML = 1, NP = W * HT;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    lmfe_window_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    lmfe_window_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(HT), .WIN(WN), .AW(AW), .MED_LAT(ML))
        dut (.clk(clk), .RST(RST), .bus(bus));

    typedef struct { int fr; int x; int y; int exp; } vec_t;
    vec_t tbl [22];

    logic [DW-1:0] mem [NP];
    int scnt [256];
    int tot, acc;
    logic [DW-1:0] med_v;
    int cyc = 0, ov_n = 0, sclr_n = 0, done_n = 0, del_bad = 0, re_n = 0, op_n = 0;
    int last_ov_cyc = 0, done_cyc = 0, ov_base = 0, sclr_base = 0;
    int cap [NP];
    int sclr_cyc [8];
    int res [5][NP];
    int n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.RE) bus.Q <= mem[bus.A];

    // Counting sorter: multiset of values, median is the middle rank.
    always @(posedge clk) begin
        if (RST || bus.SCLR) begin
            for (int i = 0; i < 256; i++) scnt[i] <= 0;
        end else if (!bus.SE && !(bus.DEL_EN && bus.DEL == bus.INS)) begin
            scnt[bus.INS] <= scnt[bus.INS] + 1;
            if (bus.DEL_EN) scnt[bus.DEL] <= scnt[bus.DEL] - 1;
        end
    end

    always_comb begin
        tot = 0;
        for (int i = 0; i < 256; i++) tot += scnt[i];
        acc = 0;
        med_v = '0;
        for (int i = 0; i < 256; i++) begin
            if (acc <= tot / 2 && acc + scnt[i] > tot / 2) med_v = 8'(i);
            acc += scnt[i];
        end
    end
    assign bus.MED = med_v;

    always @(negedge clk) begin
        if (bus.OV) begin
            if (ov_n - ov_base >= 0 && ov_n - ov_base < NP) cap[ov_n - ov_base] <= int'(bus.DOUT);
            ov_n <= ov_n + 1;
            last_ov_cyc <= cyc;
        end
        if (bus.DONE) begin
            done_n <= done_n + 1;
            done_cyc <= cyc;
        end
        if (bus.SCLR) begin
            if (sclr_n - sclr_base >= 0 && sclr_n - sclr_base < 8) sclr_cyc[sclr_n - sclr_base] <= cyc;
            sclr_n <= sclr_n + 1;
        end
        if (bus.RE) re_n <= re_n + 1;
        if (!bus.SE) begin
            op_n <= op_n + 1;
            if (bus.DEL_EN && scnt[bus.DEL] == 0) del_bad <= del_bad + 1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_rst(input string t);
        check({t, "_A"}, int'(bus.A), 0);       check({t, "_RE"}, int'(bus.RE), 0);
        check({t, "_SCLR"}, int'(bus.SCLR), 0); check({t, "_SE"}, int'(bus.SE), 1);
        check({t, "_INS"}, int'(bus.INS), 0);   check({t, "_DEL"}, int'(bus.DEL), 0);
        check({t, "_DELEN"}, int'(bus.DEL_EN), 0); check({t, "_DOUT"}, int'(bus.DOUT), 0);
        check({t, "_OV"}, int'(bus.OV), 0);     check({t, "_BZ"}, int'(bus.BZ), 0);
        check({t, "_DONE"}, int'(bus.DONE), 0);
    endtask

    task automatic set_frame(input logic ramp);
        for (int i = 0; i < NP; i++) mem[i] = ramp ? 8'(i) : 8'd5;
    endtask

    function automatic int ref_med(input int x, input int y, input logic pad);
        int v [WN*WN];
        int n, xx, yy, xc, yc, t;
        n = 0;
        for (int j = -(WN/2); j <= WN/2; j++)
            for (int i = -(WN/2); i <= WN/2; i++) begin
                xx = x + i; yy = y + j;
                xc = (xx < 0) ? 0 : ((xx >= W) ? W - 1 : xx);
                yc = (yy < 0) ? 0 : ((yy >= HT) ? HT - 1 : yy);
                v[n] = ((xx == xc && yy == yc) || pad) ? int'(mem[yc*W + xc]) : 0;
                n++;
            end
        for (int a = 0; a < WN*WN; a++)
            for (int b = 0; b < WN*WN - 1 - a; b++)
                if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
        return v[(WN*WN)/2];
    endfunction

    // mode 1: caller is in the DONE cycle; START held two cycles, first must be ignored.
    task automatic run_frame(input int fr, input logic ramp, input logic pad, input int mode, input logic poke);
        int t, d0, dn0, del0, bad;
        string nm;
        nm = $sformatf("f%0d", fr);
        if (mode == 0) begin repeat (2) @(negedge clk); #1; end
        set_frame(ramp);
        d0 = done_cyc; dn0 = done_n; del0 = del_bad;
        ov_base = ov_n; sclr_base = sclr_n;
        bus.START = 1'b1; bus.PAD = pad;
        @(negedge clk); #1;
        if (mode == 1) begin @(negedge clk); #1; end
        bus.START = 1'b0; bus.PAD = ~pad;
        if (poke) begin
            repeat (40) @(negedge clk); #1;
            bus.START = 1'b1;
            @(negedge clk); #1;
            bus.START = 1'b0;
        end
        t = 0;
        while (done_n == dn0 && t < 3000) begin @(negedge clk); #1; t++; end
        check({nm, "_done"}, done_n - dn0, 1);
        check({nm, "_ovcount"}, ov_n - ov_base, NP);
        check({nm, "_done_gap"}, done_cyc - last_ov_cyc, 1);
        check({nm, "_sclr_count"}, sclr_n - sclr_base, HT);
        check({nm, "_row0_time"}, sclr_cyc[1] - sclr_cyc[0], 31);
        check({nm, "_row2_time"}, sclr_cyc[3] - sclr_cyc[2], 31);
        check({nm, "_del_absent"}, del_bad - del0, 0);
        bad = 0;
        for (int y = 0; y < HT; y++)
            for (int x = 0; x < W; x++)
                if (cap[y*W + x] != ref_med(x, y, pad)) bad++;
        check({nm, "_ref_mism"}, bad, 0);
        if (mode == 1) check({nm, "_restart_gap"}, sclr_cyc[0] - d0, 2);
        for (int i = 0; i < NP; i++) res[fr][i] = cap[i];
    endtask

    initial begin
        int t, bad, ov0, re0, op0;
        tbl[0]  = '{0, 0, 0, 0}; tbl[1]  = '{0, 3, 0, 0}; tbl[2]  = '{0, 0, 3, 0};
        tbl[3]  = '{0, 3, 3, 0}; tbl[4]  = '{0, 1, 0, 5}; tbl[5]  = '{0, 0, 2, 5};
        tbl[6]  = '{0, 1, 1, 5}; tbl[7]  = '{0, 2, 2, 5};
        tbl[8]  = '{1, 0, 0, 5}; tbl[9]  = '{1, 3, 3, 5}; tbl[10] = '{1, 2, 1, 5};
        tbl[11] = '{2, 1, 1, 5}; tbl[12] = '{2, 0, 0, 1}; tbl[13] = '{2, 3, 3, 14};
        tbl[14] = '{2, 3, 0, 3};
        tbl[15] = '{3, 1, 1, 5}; tbl[16] = '{3, 0, 0, 1};
        tbl[17] = '{4, 0, 0, 0}; tbl[18] = '{4, 1, 1, 5}; tbl[19] = '{4, 2, 1, 6};
        tbl[20] = '{4, 3, 3, 0}; tbl[21] = '{4, 1, 0, 1};

        bus.START = 1'b0; bus.PAD = 1'b0;
        set_frame(1'b0);
        repeat (3) @(negedge clk); #1;
        check_rst("init");
        RST = 1'b0;

        run_frame(0, 1'b0, 1'b0, 0, 1'b1);
        run_frame(1, 1'b0, 1'b1, 0, 1'b0);
        run_frame(2, 1'b1, 1'b1, 0, 1'b0);
        run_frame(3, 1'b1, 1'b1, 1, 1'b0);
        bad = 0;
        for (int i = 0; i < NP; i++) if (res[3][i] != res[2][i]) bad++;
        check("repeat_frame_diff", bad, 0);
        run_frame(4, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 22; i++)
            check($sformatf("tbl%0d_f%0d_x%0d_y%0d", i, tbl[i].fr, tbl[i].x, tbl[i].y),
                  res[tbl[i].fr][tbl[i].y*W + tbl[i].x], tbl[i].exp);

        // Abort in the middle of a slide.
        repeat (2) @(negedge clk); #1;
        set_frame(1'b1);
        bus.START = 1'b1; bus.PAD = 1'b0;
        @(negedge clk); #1;
        bus.START = 1'b0;
        t = 0;
        while (!(!bus.SE && bus.DEL_EN) && t < 500) begin @(negedge clk); #1; t++; end
        check("slide_reached", int'(t < 500), 1);
        RST = 1'b1;
        @(negedge clk); #1;
        check_rst("midrst");
        RST = 1'b0;
        ov0 = ov_n; re0 = re_n; op0 = op_n;
        repeat (50) @(negedge clk); #1;
        check("post_rst_ov", ov_n - ov0, 0);
        check("post_rst_re", re_n - re0, 0);
        check("post_rst_op", op_n - op0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
